crossbar_resp: RTL and testbench
================================

Name: crossbar_resp

Overview:
- Return path paired with the forward request crossbar, which compacts up to N requesters onto M downstream slots and reports each requester's slot in its per-input id.
- crossbar_resp captures that id mapping at dispatch time, holds an owner table per downstream slot and routes each slot's response back to the requester that owns it.
- Provides per-slot busy status, per-slot timeout recovery and a sticky protocol-error flag.
- Sits between the M downstream responders and the N upstream requesters.

Parameters:
- DATA_W, 16, response data width.
- N, 7, number of upstream requesters; N >= M is checked at elaboration and fails with $fatal.
- M, 6, number of downstream slots.
- ID_W, $clog2(N), width of the slot id and of the stored owner index.
- TMO_W, 8, per-slot timeout counter width; TMO_MAX = 2**TMO_W-1.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- disp_valid  in  N  requester i is dispatched this cycle.
- disp_id  in  ID_W x N  slot id assigned to requester i (forward crossbar oid).
- busy  out  M  slot j holds an outstanding owner (registered).
- rvalid  in  M  slot j returns a response this cycle.
- rdata  in  DATA_W x M  response data of slot j.
- ovalid  out  N  response delivered to requester i (registered pulse).
- odata  out  DATA_W x N  response data for requester i.
- otimeout  out  N  one-cycle pulse: requester i's slot timed out.
- err  out  1  sticky protocol error.

Behaviour:
- Reset, asynchronous, active-high:
  - busy, ovalid, otimeout and err = 0; odata = 0.
  - All owner entries invalid; all timeout counters = 0.
  - Reset mid-transaction drops outstanding owners; no responses or timeouts are delivered for them.
- Per-slot state machine with two states:
  - IDLE -> OWNED on a capture.
  - OWNED -> IDLE on a response or a timeout.
  - busy[j] = (state == OWNED).
- Capture, on a clock edge:
  - Condition: disp_valid[i]=1 and disp_id[i] < M. Slot j=disp_id[i] records owner=i, its counter clears and it becomes OWNED.
  - disp_valid[i]=1 with disp_id[i] >= M: ignored, no error. This is the forward crossbar's overflow case.
- Response, slot j OWNED and rvalid[j]=1:
  - Next cycle: ovalid[owner]=1 and odata[owner]=rdata[j]. Latency is exactly 1 cycle.
  - The slot returns to IDLE on the same edge.
  - odata holds its last value when ovalid=0.
- Timeout:
  - The counter increments each OWNED cycle without rvalid.
  - When the counter equals TMO_MAX and rvalid[j]=0: next cycle otimeout[owner]=1 and ovalid[owner]=0; the slot goes to IDLE.
  - If rvalid arrives in the same cycle as the counter reaches TMO_MAX, the response wins and no timeout is raised.
- Simultaneous free and capture on the same slot: if slot j is OWNED with rvalid[j]=1 or a timeout that cycle, and a new dispatch targets j, then:
  - The old owner gets its response or timeout.
  - The new owner is captured.
  - busy[j] stays 1.
- err is set (sticky until rst) on any of:
  - Dispatch to an OWNED slot that is not freed that cycle. The old owner is kept and the dispatch is dropped.
  - Two or more disp_valid inputs with the same in-range disp_id in one cycle. The lowest index is captured; the others are dropped.
  - rvalid[j]=1 on an IDLE slot. The response is discarded.
- Uniqueness of requesters:
  - A requester owns at most one slot; the upstream protocol guarantees it, so ovalid/otimeout for one requester never collide.
  - A violation (dispatch of an i that already owns a slot) sets err. The new capture proceeds and the old slot is released silently.
- Width rules:
  - Counters saturate only via the timeout transition and never wrap.
  - Owner index compare/decode uses ID_W bits, zero-extended where needed.

Decomposition:
- Shared package crossbar_pkg holds:
  - the ID_W derivation function;
  - slot_state_t enum {SLOT_IDLE, SLOT_OWNED};
  - the owner_t typedef (logic[ID_W-1:0]);
  - the TMO_W default constant.
- One sub-module, crossbar_resp_slot, is instantiated M times. It contains the state flop, owner register and timeout counter, and outputs busy, owner, resp_fire and tmo_fire.
- The top level contains the dispatch decode, the collision/err logic and the owner-to-requester output mux/registers.

Test Plan (N=7, M=6, TMO_W=8 unless noted):
- Basic route: disp_valid=7'b0000101 with ids 0 and 1, then rvalid[1]=1 with rdata=16'hBEEF 3 cycles later -> one cycle after rvalid: ovalid=7'b0000100, odata[2]=16'hBEEF; busy goes 2'b11 -> 2'b01.
- Overflow ignored: all 7 requesters dispatched with disp_id[6]=6 -> busy=6'h3F, err=0; requester 6 never receives ovalid.
- Timeout with TMO_W=4: slot 3 owned by requester 5 with no rvalid -> otimeout[5] pulses at cycle 16 after capture, busy[3]=0, ovalid stays 0; rvalid[3] arriving in the same cycle as the timeout instead gives ovalid[5] and no otimeout.
- Free and capture: slot 0 owned by requester 1; in the same cycle rvalid[0]=1 and requester 4 dispatches to slot 0 -> ovalid[1] next cycle, busy[0] stays 1, owner=4, err=0.
- Errors: dispatch to an owned slot with no rvalid -> err=1 and the original owner is preserved; rvalid on an idle slot -> err=1 and no ovalid.
- Reset mid-operation: 3 slots owned, rst asserted asynchronously between edges -> busy/ovalid/otimeout/err immediately 0; no deliveries after rst deasserts.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar response path.
// Holds the slot state encoding, owner index type and default widths.
package crossbar_pkg;

  localparam int unsigned TMO_W_DEFAULT = 8;

  // Width of a slot id / owner index for n requesters (at least 1 bit).
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ID_W_DEFAULT = id_width(7);

  typedef enum logic {
    SLOT_IDLE  = 1'b0,
    SLOT_OWNED = 1'b1
  } slot_state_t;

  typedef logic [ID_W_DEFAULT-1:0] owner_t;

endpackage

// File: rtl/crossbar_resp_slot.sv
// One downstream slot: ownership state, owner index and timeout counter.
// Fires resp_fire/tmo_fire combinationally in the cycle the slot is freed.
module crossbar_resp_slot
  import crossbar_pkg::*;
#(
  parameter int unsigned ID_W  = ID_W_DEFAULT,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap,
  input  logic [ID_W-1:0] cap_owner,
  input  logic            rel,
  input  logic            rvalid,
  output logic            busy,
  output logic [ID_W-1:0] owner,
  output logic            resp_fire,
  output logic            tmo_fire
);

  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  slot_state_t      state, state_n;
  logic [ID_W-1:0]  owner_q, owner_n;
  logic [TMO_W-1:0] cnt, cnt_n;

  assign busy      = (state == SLOT_OWNED);
  assign owner     = owner_q;
  assign resp_fire = busy && rvalid;
  // A response in the same cycle as the last count wins over the timeout.
  assign tmo_fire  = busy && !rvalid && (cnt == TMO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SLOT_IDLE;
      owner_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      owner_q <= owner_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner_q;
    cnt_n   = cnt;
    case (state)
      SLOT_IDLE: begin
        if (cap) begin
          state_n = SLOT_OWNED;
          owner_n = cap_owner;
          cnt_n   = '0;
        end
      end
      SLOT_OWNED: begin
        // cap is only granted here when the slot is also being freed
        if (cap) begin
          owner_n = cap_owner;
          cnt_n   = '0;
        end else if (resp_fire || tmo_fire || rel) begin
          state_n = SLOT_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + TMO_W'(1);
        end
      end
      default: state_n = SLOT_IDLE;
    endcase
  end

endmodule

// File: rtl/crossbar_resp.sv
// Response return path for the request crossbar: captures slot ownership at
// dispatch, routes each slot's response or timeout back to its owner.
module crossbar_resp
  import crossbar_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 7,
  parameter int unsigned M      = 6,
  parameter int unsigned ID_W   = id_width(N),
  parameter int unsigned TMO_W  = TMO_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           disp_valid,
  input  logic [N-1:0][ID_W-1:0] disp_id,
  output logic [M-1:0]           busy,
  input  logic [M-1:0]           rvalid,
  input  logic [M-1:0][DATA_W-1:0] rdata,
  output logic [N-1:0]           ovalid,
  output logic [N-1:0][DATA_W-1:0] odata,
  output logic [N-1:0]           otimeout,
  output logic                   err
);

  if (N < M) begin : g_bad_cfg
    $fatal(1, "crossbar_resp: N must be >= M");
  end

  logic [M-1:0][ID_W-1:0]   owner;
  logic [M-1:0][ID_W-1:0]   win;
  logic [M-1:0]             resp_fire, tmo_fire, live;
  logic [M-1:0]             cap_req, cap, rel, dup;
  logic [N-1:0]             in_range, acc;
  logic [N-1:0]             ovalid_n, otimeout_n;
  logic [N-1:0][DATA_W-1:0] odata_n;
  logic                     held_err, err_n;

  for (genvar j = 0; j < M; j++) begin : g_slot
    crossbar_resp_slot #(
      .ID_W (ID_W),
      .TMO_W(TMO_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .cap      (cap[j]),
      .cap_owner(win[j]),
      .rel      (rel[j]),
      .rvalid   (rvalid[j]),
      .busy     (busy[j]),
      .owner    (owner[j]),
      .resp_fire(resp_fire[j]),
      .tmo_fire (tmo_fire[j])
    );
  end

  // Slot still held after this edge (owned and neither answered nor timed out).
  assign live = busy & ~(resp_fire | tmo_fire);
  assign cap  = cap_req & ~live;

  // Dispatch decode: lowest requester index wins each slot.
  always_comb begin
    in_range = '0;
    cap_req  = '0;
    dup      = '0;
    win      = '0;
    for (int i = 0; i < N; i++) begin
      in_range[i] = ({1'b0, disp_id[i]} < (ID_W+1)'(M));
    end
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        if (disp_valid[i] && in_range[i] && (disp_id[i] == ID_W'(j))) begin
          if (cap_req[j]) begin
            dup[j] = 1'b1;
          end else begin
            cap_req[j] = 1'b1;
            win[j]     = ID_W'(i);
          end
        end
      end
    end
  end

  // A requester re-dispatched while still holding another slot gives that slot up.
  always_comb begin
    acc      = '0;
    rel      = '0;
    held_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (cap[j] && (win[j] == ID_W'(i))) acc[i] = 1'b1;
      end
    end
    for (int k = 0; k < M; k++) begin
      for (int i = 0; i < N; i++) begin
        if (live[k] && (owner[k] == ID_W'(i))) begin
          if (acc[i]) rel[k] = 1'b1;
          if (disp_valid[i] && in_range[i]) held_err = 1'b1;
        end
      end
    end
  end

  assign err_n = err | (|dup) | (|(cap_req & live)) | held_err | (|(rvalid & ~busy));

  // Owner-to-requester return mux; odata holds when nothing is delivered.
  always_comb begin
    ovalid_n   = '0;
    otimeout_n = '0;
    odata_n    = odata;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        if (owner[j] == ID_W'(i)) begin
          if (resp_fire[j]) begin
            ovalid_n[i] = 1'b1;
            odata_n[i]  = rdata[j];
          end
          if (tmo_fire[j]) otimeout_n[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovalid   <= '0;
      otimeout <= '0;
      odata    <= '0;
      err      <= 1'b0;
    end else begin
      ovalid   <= ovalid_n;
      otimeout <= otimeout_n;
      odata    <= odata_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_crossbar_resp.sv
// Self-checking bench for crossbar_resp: directed scenarios plus random
// traffic checked against an ownership-table reference model.
module tb_crossbar_resp;

  localparam int DATA_W  = 16;
  localparam int N       = 7;
  localparam int M       = 6;
  localparam int ID_W    = 3;
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic                     clk, rst;
  logic [N-1:0]             disp_valid;
  logic [N-1:0][ID_W-1:0]   disp_id;
  logic [M-1:0]             busy;
  logic [M-1:0]             rvalid;
  logic [M-1:0][DATA_W-1:0] rdata;
  logic [N-1:0]             ovalid;
  logic [N-1:0][DATA_W-1:0] odata;
  logic [N-1:0]             otimeout;
  logic                     err;

  crossbar_resp #(
    .DATA_W(DATA_W), .N(N), .M(M), .ID_W(ID_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_id(disp_id),
    .busy(busy), .rvalid(rvalid), .rdata(rdata), .ovalid(ovalid),
    .odata(odata), .otimeout(otimeout), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int passed = 0;
  int total  = 0;

  // Reference model: who owns each slot and how long it has waited.
  bit                       m_own[M];
  int                       m_owner[M];
  int                       m_age[M];
  logic [N-1:0]             exp_ovalid, exp_otmo;
  logic [N-1:0][DATA_W-1:0] exp_odata;
  logic                     exp_err;

  task automatic model_reset();
    for (int j = 0; j < M; j++) begin
      m_own[j] = 0; m_owner[j] = 0; m_age[j] = 0;
    end
    exp_ovalid = '0; exp_otmo = '0; exp_odata = '0; exp_err = 1'b0;
  endtask

  function automatic logic [M-1:0] model_busy();
    logic [M-1:0] b;
    for (int j = 0; j < M; j++) b[j] = m_own[j];
    return b;
  endfunction

  function automatic bit slot_frees(int j);
    return m_own[j] && (rvalid[j] || m_age[j] == TMO_MAX);
  endfunction

  task automatic model_step();
    bit fr[M];
    bit claimed[M];
    bit rel[M];
    int newown[M];
    for (int j = 0; j < M; j++) begin
      fr[j] = slot_frees(j); claimed[j] = 0; rel[j] = 0; newown[j] = -1;
    end
    exp_ovalid = '0;
    exp_otmo   = '0;
    for (int j = 0; j < M; j++) begin
      if (m_own[j]) begin
        if (rvalid[j]) begin
          exp_ovalid[m_owner[j]] = 1'b1;
          exp_odata[m_owner[j]]  = rdata[j];
        end else if (m_age[j] == TMO_MAX) begin
          exp_otmo[m_owner[j]] = 1'b1;
        end
      end else if (rvalid[j]) begin
        exp_err = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (disp_valid[i] && int'(disp_id[i]) < M) begin
        int j, held;
        j = int'(disp_id[i]);
        held = -1;
        for (int k = 0; k < M; k++)
          if (m_own[k] && !fr[k] && m_owner[k] == i) held = k;
        if (held >= 0) exp_err = 1'b1;
        if (claimed[j]) begin
          exp_err = 1'b1;
        end else begin
          claimed[j] = 1;
          if (m_own[j] && !fr[j]) begin
            exp_err = 1'b1;
          end else begin
            newown[j] = i;
            if (held >= 0) rel[held] = 1;
          end
        end
      end
    end
    for (int j = 0; j < M; j++) begin
      if (newown[j] >= 0) begin
        m_own[j] = 1; m_owner[j] = newown[j]; m_age[j] = 0;
      end else if (fr[j] || rel[j]) begin
        m_own[j] = 0; m_age[j] = 0;
      end else if (m_own[j]) begin
        m_age[j]++;
      end
    end
  endtask

  task automatic drive_idle();
    disp_valid = '0; disp_id = '0; rvalid = '0; rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    total++; if (busy !== '0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (ovalid !== '0) $display("FAIL reset_ovalid got=%b exp=0", ovalid); else passed++;
    total++; if (otimeout !== '0) $display("FAIL reset_otimeout got=%b exp=0", otimeout); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passed++;
    total++; if (odata !== '0) $display("FAIL reset_odata got=%h exp=0", odata); else passed++;
    do_reset();
  endtask

  task automatic test_basic_route();
    do_reset();
    disp_valid = 7'b0000101; disp_id[0] = 3'd0; disp_id[2] = 3'd1;
    tick();
    drive_idle();
    total++; if (busy !== 6'b000011) $display("FAIL route_busy_cap got=%b exp=000011", busy); else passed++;
    tick(); tick();
    rvalid[1] = 1'b1; rdata[1] = 16'hBEEF;
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0000100) $display("FAIL route_ovalid got=%b exp=0000100", ovalid); else passed++;
    total++; if (odata[2] !== 16'hBEEF) $display("FAIL route_odata got=%h exp=beef", odata[2]); else passed++;
    total++; if (busy !== 6'b000001) $display("FAIL route_busy_free got=%b exp=000001", busy); else passed++;
    tick();
    total++; if (ovalid !== '0 || odata[2] !== 16'hBEEF)
      $display("FAIL route_hold got ovalid=%b odata=%h exp ovalid=0 odata=beef", ovalid, odata[2]); else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    disp_valid = '1;
    for (int i = 0; i < N; i++) disp_id[i] = ID_W'(i);
    tick();
    drive_idle();
    total++; if (busy !== 6'h3F) $display("FAIL ovf_busy got=%b exp=111111", busy); else passed++;
    total++; if (err !== 1'b0) $display("FAIL ovf_err got=%b exp=0", err); else passed++;
    rvalid = '1;
    for (int j = 0; j < M; j++) rdata[j] = DATA_W'(16'h1000 + j);
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0111111) $display("FAIL ovf_ovalid got=%b exp=0111111", ovalid); else passed++;
    total++; if (odata[4] !== 16'h1004) $display("FAIL ovf_odata got=%h exp=1004", odata[4]); else passed++;
  endtask

  task automatic test_timeout();
    bit early;
    bit held;
    do_reset();
    disp_valid[5] = 1'b1; disp_id[5] = 3'd3;
    tick();
    drive_idle();
    early = 0; held = 1;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (otimeout !== '0) early = 1;
      if (busy[3] !== 1'b1) held = 0;
    end
    total++; if (early || !held) $display("FAIL tmo_early got early=%0d held=%0d exp early=0 held=1", early, held); else passed++;
    tick();
    total++; if (otimeout !== 7'b0100000) $display("FAIL tmo_pulse got=%b exp=0100000", otimeout); else passed++;
    total++; if (busy !== '0 || ovalid !== '0) $display("FAIL tmo_state got busy=%b ovalid=%b exp 0/0", busy, ovalid); else passed++;
    tick();
    total++; if (otimeout !== '0) $display("FAIL tmo_one_cycle got=%b exp=0", otimeout); else passed++;
    // response arriving on the final count beats the timeout
    do_reset();
    disp_valid[5] = 1'b1; disp_id[5] = 3'd3;
    tick();
    drive_idle();
    for (int k = 1; k < 16; k++) tick();
    rvalid[3] = 1'b1; rdata[3] = 16'h1234;
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0100000 || otimeout !== '0)
      $display("FAIL tmo_race got ovalid=%b otimeout=%b exp 0100000/0", ovalid, otimeout); else passed++;
    total++; if (odata[5] !== 16'h1234) $display("FAIL tmo_race_data got=%h exp=1234", odata[5]); else passed++;
  endtask

  task automatic test_free_and_capture();
    do_reset();
    disp_valid[1] = 1'b1; disp_id[1] = 3'd0;
    tick();
    drive_idle();
    rvalid[0] = 1'b1; rdata[0] = 16'hA5A5;
    disp_valid[4] = 1'b1; disp_id[4] = 3'd0;
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0000010 || odata[1] !== 16'hA5A5)
      $display("FAIL fc_old got ovalid=%b odata=%h exp 0000010/a5a5", ovalid, odata[1]); else passed++;
    total++; if (busy[0] !== 1'b1 || err !== 1'b0)
      $display("FAIL fc_busy got busy0=%b err=%b exp 1/0", busy[0], err); else passed++;
    rvalid[0] = 1'b1; rdata[0] = 16'h5A5A;
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0010000 || odata[4] !== 16'h5A5A)
      $display("FAIL fc_new got ovalid=%b odata=%h exp 0010000/5a5a", ovalid, odata[4]); else passed++;
  endtask

  task automatic test_errors();
    do_reset();
    disp_valid[1] = 1'b1; disp_id[1] = 3'd2;
    tick();
    drive_idle();
    disp_valid[3] = 1'b1; disp_id[3] = 3'd2;
    tick();
    drive_idle();
    total++; if (err !== 1'b1 || busy !== 6'b000100)
      $display("FAIL err_owned got err=%b busy=%b exp 1/000100", err, busy); else passed++;
    rvalid[2] = 1'b1; rdata[2] = 16'h0F0F;
    tick();
    drive_idle();
    total++; if (ovalid !== 7'b0000010) $display("FAIL err_keep_owner got=%b exp=0000010", ovalid); else passed++;
    do_reset();
    rvalid[4] = 1'b1; rdata[4] = 16'hDEAD;
    tick();
    drive_idle();
    total++; if (err !== 1'b1 || ovalid !== '0)
      $display("FAIL err_idle_rsp got err=%b ovalid=%b exp 1/0", err, ovalid); else passed++;
    do_reset();
    disp_valid = 7'b0100100; disp_id[2] = 3'd3; disp_id[5] = 3'd3;
    tick();
    drive_idle();
    rvalid[3] = 1'b1; rdata[3] = 16'h7777;
    tick();
    drive_idle();
    total++; if (err !== 1'b1 || ovalid !== 7'b0000100)
      $display("FAIL err_dup got err=%b ovalid=%b exp 1/0000100", err, ovalid); else passed++;
  endtask

  task automatic test_reset_mid();
    bit quiet;
    do_reset();
    disp_valid = 7'b0000111; disp_id[0] = 3'd0; disp_id[1] = 3'd1; disp_id[2] = 3'd2;
    rvalid[5] = 1'b1;
    tick();
    drive_idle();
    total++; if (err !== 1'b1 || busy !== 6'b000111)
      $display("FAIL rstmid_pre got err=%b busy=%b exp 1/000111", err, busy); else passed++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (busy !== '0 || ovalid !== '0 || otimeout !== '0 || err !== 1'b0)
      $display("FAIL rstmid_async got busy=%b ovalid=%b otmo=%b err=%b exp all 0", busy, ovalid, otimeout, err); else passed++;
    #1;
    rst = 1'b0;
    quiet = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ovalid !== '0 || otimeout !== '0 || busy !== '0) quiet = 0;
    end
    total++; if (!quiet) $display("FAIL rstmid_quiet got activity after reset exp none"); else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      bit clean;
      bit claimed[M];
      clean = (c < 400);
      drive_idle();
      for (int j = 0; j < M; j++) begin
        claimed[j] = 0;
        rdata[j] = DATA_W'($urandom);
        if (clean) rvalid[j] = m_own[j] && ($urandom_range(0, 9) == 0);
        else       rvalid[j] = ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < N; i++) begin
        int id;
        bit holds;
        id = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) begin
          if (!clean) begin
            disp_valid[i] = 1'b1; disp_id[i] = ID_W'(id);
          end else begin
            holds = 0;
            for (int k = 0; k < M; k++)
              if (m_own[k] && !slot_frees(k) && m_owner[k] == i) holds = 1;
            if (!holds && id >= M) begin
              disp_valid[i] = 1'b1; disp_id[i] = ID_W'(id);
            end else if (!holds && !claimed[id] && (!m_own[id] || slot_frees(id))) begin
              claimed[id] = 1;
              disp_valid[i] = 1'b1; disp_id[i] = ID_W'(id);
            end
          end
        end
      end
      tick();
      total++; if (busy !== model_busy()) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, model_busy()); else passed++;
      total++; if (ovalid !== exp_ovalid) $display("FAIL rnd_ovalid cyc=%0d got=%b exp=%b", c, ovalid, exp_ovalid); else passed++;
      total++; if (otimeout !== exp_otmo) $display("FAIL rnd_otimeout cyc=%0d got=%b exp=%b", c, otimeout, exp_otmo); else passed++;
      total++; if (odata !== exp_odata) $display("FAIL rnd_odata cyc=%0d got=%h exp=%h", c, odata, exp_odata); else passed++;
      total++; if (err !== exp_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, exp_err); else passed++;
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    model_reset();
    test_reset();
    test_basic_route();
    test_overflow();
    test_timeout();
    test_free_and_capture();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
